// File: rtl/matrix_scanner.sv
// Row-scanning driver for the 8x8 LED matrix: requests a row index, captures the
// returned bitmap and lights one row at a time with blanking between rows.
module matrix_scanner #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int BIT_OF_ROWS    = 3,
    parameter int FETCH_CYCLES   = 2,
    parameter int BLANK_CYCLES   = 16,
    parameter int DWELL_CYCLES   = 1000,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [15:0]            row_data_in,
    output logic [BIT_OF_ROWS-1:0] count,
    output logic [ROWS-1:0]        row_sel,
    output logic [COLS-1:0]        col_out,
    output logic                   frame_start
);

    localparam int MAX_A = (FETCH_CYCLES > BLANK_CYCLES) ? FETCH_CYCLES : BLANK_CYCLES;
    localparam int MAXC  = (MAX_A > DWELL_CYCLES) ? MAX_A : DWELL_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);
    localparam logic [ROWS-1:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_BLANK, S_SHOW} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cyc, w_cyc_nxt;
    logic [BIT_OF_ROWS-1:0] r_count, w_count_nxt;
    logic [COLS-1:0]        r_shadow;
    logic [ROWS-1:0]        r_row_sel, w_row_sel_nxt, w_onehot;
    logic [COLS-1:0]        r_col, w_col_nxt;
    logic                   r_fs, w_fs_nxt;
    logic                   w_load;

    generate
        if (COLS < 16) begin : g_unused
            logic w_unused_hi;
            assign w_unused_hi = ^row_data_in[15:COLS];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc + 1'b1;
        w_count_nxt = r_count;
        w_load      = 1'b0;
        w_fs_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cyc_nxt = '0;
                if (enable) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (r_cyc == CW'(FETCH_CYCLES - 1)) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_BLANK;
                    w_cyc_nxt   = '0;
                end
            end
            S_BLANK: begin
                if (r_cyc == CW'(BLANK_CYCLES - 1)) begin
                    w_state_nxt = S_SHOW;
                    w_cyc_nxt   = '0;
                    w_fs_nxt    = (r_count == '0);
                end
            end
            S_SHOW: begin
                if (r_cyc == CW'(DWELL_CYCLES - 1)) begin
                    w_state_nxt = S_FETCH;
                    w_cyc_nxt   = '0;
                    w_count_nxt = (r_count == BIT_OF_ROWS'(ROWS - 1)) ? '0
                                                                     : r_count + BIT_OF_ROWS'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cyc_nxt   = '0;
            end
        endcase
        // Disable wins over every transition and throws away the partial row.
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cyc_nxt   = '0;
            w_count_nxt = '0;
            w_load      = 1'b0;
            w_fs_nxt    = 1'b0;
        end
    end

    // Outputs are derived from the next state so the registered pins line up with r_state.
    always_comb begin
        w_onehot      = {{(ROWS-1){1'b0}}, 1'b1} << w_count_nxt;
        w_row_sel_nxt = ROW_OFF;
        w_col_nxt     = '0;
        if (w_state_nxt == S_SHOW) begin
            w_row_sel_nxt = (ROW_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
            w_col_nxt     = r_shadow;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cyc     <= '0;
            r_count   <= '0;
            r_shadow  <= '0;
            r_row_sel <= ROW_OFF;
            r_col     <= '0;
            r_fs      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cyc     <= w_cyc_nxt;
            r_count   <= w_count_nxt;
            r_row_sel <= w_row_sel_nxt;
            r_col     <= w_col_nxt;
            r_fs      <= w_fs_nxt;
            if (w_load) r_shadow <= row_data_in[COLS-1:0];
        end
    end

    assign count       = r_count;
    assign row_sel     = r_row_sel;
    assign col_out     = r_col;
    assign frame_start = r_fs;

endmodule

// File: doc/matrix_scanner.md
Name: matrix_scanner

Overview:
- Consumer end of the row-data interface of the pong display path.
- Generates the row index `count` that the game logic uses to build each row.
- Captures the returned row bitmap and drives the 8x8 LED matrix row-select and column lines with time-multiplexed scanning.
- Inserts blanking between rows to prevent ghosting and emits a frame-start pulse.

Parameters:
- ROWS, 8, number of matrix rows scanned; row index wraps at ROWS-1.
- COLS, 8, number of columns driven; the low COLS bits of row_data_in are used.
- BIT_OF_ROWS, 3, width of `count`; must satisfy 2**BIT_OF_ROWS >= ROWS.
- FETCH_CYCLES, 2, cycles `count` is held before row_data_in is captured; covers the 1-cycle registered latency of the row source plus margin. Minimum 2.
- BLANK_CYCLES, 16, cycles with all rows off before a row is lit. Minimum 1.
- DWELL_CYCLES, 1000, cycles each row stays lit. Minimum 1.
- ROW_ACTIVE_LOW, 1, 1 = a selected row is driven 0, 0 = a selected row is driven 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scanning runs; 0 = display off.
- row_data_in  input  16  row bitmap from the game logic; bit i lights column i. Bits [15:COLS] are ignored.
- count  output  BIT_OF_ROWS  row index requested from the game logic. Also the row currently being fetched or shown.
- row_sel  output  ROWS  row drive; at most one row is active at any time.
- col_out  output  COLS  column drive, active-high.
- frame_start  output  1  one-cycle pulse when row 0 becomes lit.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - state=IDLE, count=0, shadow register=0, col_out=0, frame_start=0.
  - row_sel = all inactive: all 1s if ROW_ACTIVE_LOW, else all 0s.
  - All cycle counters = 0.
  - Reset asserted mid-scan takes effect immediately; no row stays lit.
- States: IDLE, FETCH, BLANK, SHOW.
- IDLE:
  - Outputs are inactive and count=0.
  - Moves to FETCH on the first rising edge where enable=1.
- FETCH:
  - Lasts exactly FETCH_CYCLES cycles.
  - count holds the current row; row_sel is inactive and col_out=0.
  - On the last FETCH cycle, the shadow register loads row_data_in[COLS-1:0].
  - Then moves to BLANK.
- BLANK:
  - Lasts exactly BLANK_CYCLES cycles.
  - row_sel is inactive and col_out=0. count is unchanged.
  - Then moves to SHOW.
- SHOW:
  - Lasts exactly DWELL_CYCLES cycles.
  - row_sel drives only bit [count] active; col_out = shadow register.
  - The shadow register does not change during SHOW, even if row_data_in changes.
  - On leaving SHOW: count increments, wrapping from ROWS-1 to 0, and the state moves to FETCH.
- frame_start:
  - High for exactly the first SHOW cycle of row 0.
  - Low in every other cycle.
- Timing:
  - Row period = FETCH_CYCLES + BLANK_CYCLES + DWELL_CYCLES cycles.
  - Frame period = ROWS x row period.
- enable deasserted in any state:
  - On the next rising edge, the state goes to IDLE and count=0.
  - row_sel and col_out go inactive; frame_start=0.
  - The partial row is discarded.
- enable reasserted: the scan restarts from FETCH of row 0.
- Row transition: row_sel never has two active bits, not even for one cycle. BLANK separates every pair of lit rows, including the ROWS-1 -> 0 wrap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Common bench parameters: FETCH_CYCLES=2, BLANK_CYCLES=2, DWELL_CYCLES=4, ROW_ACTIVE_LOW=1, giving a row period of 8 cycles.
- Reset then enable=1; row_data_in = 8'h18 for all rows -> count steps 0,1,...,7,0 every 8 cycles. Cycles 5-8 of each row have row_sel=~(1<<count) and col_out=8'h18. frame_start pulses once per 64 cycles, on row 0 SHOW entry.
- Model the row source as 1-cycle registered, returning 8'h01<<count -> row r shows col_out = 1<<r. Checks that capture at the end of FETCH sees the correct, not the stale, row.
- Toggle row_data_in every cycle during SHOW of row 3 -> col_out stays at the value captured in FETCH for all 4 SHOW cycles.
- Over 3 full frames -> row_sel is never anything other than all-ones or a one-hot-zero pattern. Rows ROWS-1 and 0 are separated by 2 blank cycles plus 2 fetch cycles.
- Drop enable during SHOW of row 5 -> next edge: row_sel=8'hFF, col_out=0, count=0. Reassert enable -> row 0 shows 5 cycles later, with frame_start in that cycle.
- Assert reset_n=0 asynchronously mid-SHOW, between clock edges -> row_sel=8'hFF and col_out=0 immediately. Release with enable=1 -> a normal scan restarts at row 0.
